// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pulls characters from THR/FIFO and serialises start, data, parity, stop at 16 ticks per bit.
// tsr_load one cycle after data becomes available, txd falls the cycle after; no idle gap between back-to-back frames.
module uart_tx_ctrl (
  input  logic       pclk,
  input  logic       preset,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       fifoen,
  input  logic       tx_fifo_empty,
  input  logic       thr_wr_en,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       bc,
  output logic       tsr_load,
  output logic       txd,
  output logic       thre,
  output logic       temt,
  output logic       tx_busy
);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  tsr, tsr_nxt, chr;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_cnt;
  logic [5:0]  stop_cnt, stop_last;
  logic [1:0]  wls_q;
  logic        stb_q, pen_q, eps_q, sp_q;
  logic        thr_empty, avail, bit_end, stop_end, last_bit;
  logic        data_xor, par_bit, txd_nxt;
  logic [7:0]  par_mask;

  assign avail     = fifoen ? ~tx_fifo_empty : ~thr_empty;
  assign bit_end   = baud_tick & (tick_cnt == 4'd15);
  assign last_bit  = (bit_cnt == (3'd4 + {1'b0, wls_q}));
  assign stop_last = ~stb_q ? 6'd15 : ((wls_q == 2'b00) ? 6'd23 : 6'd31);
  assign stop_end  = baud_tick & (stop_cnt == stop_last);

  // Parity comes from the character as loaded, masked to the frame's word length
  assign par_mask = 8'hFF >> (2'd3 - wls_q);
  assign data_xor = ^(chr & par_mask);
  assign par_bit  = sp_q ? ~eps_q : (eps_q ? data_xor : ~data_xor);

  assign tsr_nxt = (state == LOAD) ? tx_data :
                   ((state == DATA) && bit_end) ? {1'b0, tsr[7:1]} : tsr;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (avail) state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && last_bit) state_nxt = pen_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (stop_end) state_nxt = avail ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // txd is registered from the next state so the line moves on the same edge as the FSM
  always_comb begin
    tsr_load = (state == LOAD);
    tx_busy  = (state != IDLE);
    thre     = fifoen ? tx_fifo_empty : thr_empty;
    temt     = thre & (state == IDLE);
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = tsr_nxt[0];
      PARITY:  txd_nxt = par_bit;
      default: txd_nxt = 1'b1;
    endcase
    if (bc) txd_nxt = 1'b0;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) txd <= 1'b1;
    else        txd <= txd_nxt;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tsr       <= 8'h00;
      chr       <= 8'h00;
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      stop_cnt  <= 6'd0;
      wls_q     <= 2'b00;
      stb_q     <= 1'b0;
      pen_q     <= 1'b0;
      eps_q     <= 1'b0;
      sp_q      <= 1'b0;
      thr_empty <= 1'b1;
    end else begin
      tsr <= tsr_nxt;
      if (state == LOAD) begin
        chr      <= tx_data;
        tick_cnt <= 4'd0;
        bit_cnt  <= 3'd0;
        wls_q    <= wls;
        stb_q    <= stb;
        pen_q    <= pen;
        eps_q    <= eps;
        sp_q     <= sp;
      end else begin
        if (baud_tick && ((state == START) || (state == DATA) || (state == PARITY)))
          tick_cnt <= tick_cnt + 4'd1;
        if ((state == DATA) && bit_end)
          bit_cnt <= bit_cnt + 3'd1;
      end
      if (state != STOP)  stop_cnt <= 6'd0;
      else if (baud_tick) stop_cnt <= stop_cnt + 6'd1;
      // A host write in the same cycle as a load leaves the new character pending
      if (thr_wr_en && !fifoen)     thr_empty <= 1'b0;
      else if (tsr_load && !fifoen) thr_empty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: THR/FIFO sources, framing formats, back-to-back, break and reset.
module tb_uart_tx_ctrl;

  logic       pclk = 1'b0;
  logic       preset, baud_tick = 1'b0;
  logic [7:0] tx_data;
  logic       fifoen, tx_fifo_empty, thr_wr_en;
  logic [1:0] wls;
  logic       stb, pen, eps, sp, bc;
  logic       tsr_load, txd, thre, temt, tx_busy;

  int         n_cmp = 0, n_err = 0, n_loads = 0, l0;
  logic [7:0] thr_reg, wdat, wd;
  logic [7:0] fifo_q[$];
  logic       ld_q, wr_q, mid_thre, mid_temt;

  uart_tx_ctrl dut (
    .pclk(pclk), .preset(preset), .baud_tick(baud_tick), .tx_data(tx_data),
    .fifoen(fifoen), .tx_fifo_empty(tx_fifo_empty), .thr_wr_en(thr_wr_en),
    .wls(wls), .stb(stb), .pen(pen), .eps(eps), .sp(sp), .bc(bc),
    .tsr_load(tsr_load), .txd(txd), .thre(thre), .temt(temt), .tx_busy(tx_busy)
  );

  always #5 pclk = ~pclk;

  // Baud tick on every other cycle, changed away from both clock edges
  initial forever begin
    @(posedge pclk); #2;
    baud_tick = ~baud_tick;
  end

  initial forever begin
    @(negedge pclk);
    if (tsr_load) n_loads++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    tx_fifo_empty = (fifo_q.size() == 0);
    tx_data = fifoen ? ((fifo_q.size() != 0) ? fifo_q[0] : 8'h00) : thr_reg;
  endtask

  // THR register and FIFO pop model, updated just after the clock edge
  initial forever begin
    @(negedge pclk); ld_q = tsr_load;
    @(posedge pclk); wr_q = thr_wr_en; wd = wdat;
    #1;
    if (wr_q) thr_reg = wd;
    if (ld_q && fifoen && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh();
  end

  task automatic thr_write(input logic [7:0] d);
    @(negedge pclk);
    wdat = d; thr_wr_en = 1'b1;
    @(negedge pclk);
    thr_wr_en = 1'b0;
  endtask

  task automatic wait_load(input string tag);
    int w = 0;
    while (!tsr_load && w < 3000) begin @(negedge pclk); w++; end
    chk({tag, "_load"}, 32'(tsr_load), 32'd1);
  endtask

  // bits[0] is the start bit; sampled at mid-bit every 32 cycles from the start edge
  task automatic check_frame(input string tag, input logic [11:0] bits, input int nb,
                             input int exp_ticks, input bit in_start);
    int   cyc = 0, ticks = 0;
    logic prev = 1'b0;
    if (!in_start) begin
      wait_load(tag);
      @(negedge pclk);
    end
    do begin
      if (baud_tick) ticks++;
      prev = baud_tick;
      if ((cyc % 32) == 16 && (cyc / 32) < nb)
        chk($sformatf("%s_bit%0d", tag, cyc / 32), 32'(txd), 32'(bits[cyc / 32]));
      if (cyc == 100) begin mid_thre = thre; mid_temt = temt; end
      @(negedge pclk);
      cyc++;
    end while (tx_busy && !tsr_load && cyc < 1000);
    chk({tag, "_ticks"}, 32'(ticks), 32'(exp_ticks));
    chk({tag, "_endtick"}, 32'(prev), 32'd1);
  endtask

  initial begin
    int  w;
    logic seen_high;
    preset = 1'b1; fifoen = 1'b0; thr_wr_en = 1'b0; wdat = 8'h00; thr_reg = 8'h00;
    wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0; sp = 1'b0; bc = 1'b0;
    refresh();
    repeat (3) @(negedge pclk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_load", 32'(tsr_load), 32'd0);
    chk("rst_thre", 32'(thre), 32'd1);
    chk("rst_temt", 32'(temt), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    preset = 1'b0;
    repeat (4) @(negedge pclk);

    // 8N1 from THR
    l0 = n_loads;
    thr_write(8'hA5);
    chk("t1_thre_full", 32'(thre), 32'd0);
    chk("t1_load_early", 32'(tsr_load), 32'd0);
    @(negedge pclk);
    chk("t1_load_lat", 32'(tsr_load), 32'd1);
    check_frame("t1", {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 160, 1'b0);
    chk("t1_mid_thre", 32'(mid_thre), 32'd1);
    chk("t1_mid_temt", 32'(mid_temt), 32'd0);
    chk("t1_temt", 32'(temt), 32'd1);
    chk("t1_loads", 32'(n_loads - l0), 32'd1);

    // 7E1 then stick parity
    wls = 2'b10; pen = 1'b1; eps = 1'b1; sp = 1'b0;
    thr_write(8'h55);
    check_frame("e7", {2'b00, 1'b1, 1'b0, 7'h55, 1'b0}, 10, 160, 1'b0);
    sp = 1'b1; eps = 1'b0;
    thr_write(8'h55);
    check_frame("sp7", {2'b00, 1'b1, 1'b1, 7'h55, 1'b0}, 10, 160, 1'b0);

    // 5 bits with 1.5 stop, then 8 bits with 2 stop
    wls = 2'b00; stb = 1'b1; pen = 1'b0; sp = 1'b0;
    thr_write(8'h1F);
    check_frame("w5", {5'b00000, 1'b1, 5'h1F, 1'b0}, 7, 120, 1'b0);
    chk("w5_idle", 32'(tx_busy), 32'd0);
    chk("w5_temt", 32'(temt), 32'd1);
    wls = 2'b11;
    thr_write(8'h3C);
    check_frame("w8s2", {1'b0, 2'b11, 8'h3C, 1'b0}, 11, 176, 1'b0);

    // FIFO back-to-back
    stb = 1'b0;
    l0 = n_loads;
    @(negedge pclk);
    fifoen = 1'b1;
    fifo_q = {8'h11, 8'h22, 8'h33};
    refresh();
    @(negedge pclk);
    chk("f_thre", 32'(thre), 32'd0);
    check_frame("f1", {2'b00, 1'b1, 8'h11, 1'b0}, 10, 160, 1'b0);
    chk("f1_mid_thre", 32'(mid_thre), 32'd0);
    chk("f1_next_load", 32'(tsr_load), 32'd1);
    check_frame("f2", {2'b00, 1'b1, 8'h22, 1'b0}, 10, 160, 1'b0);
    chk("f2_next_load", 32'(tsr_load), 32'd1);
    check_frame("f3", {2'b00, 1'b1, 8'h33, 1'b0}, 10, 160, 1'b0);
    chk("f3_mid_thre", 32'(mid_thre), 32'd1);
    chk("f3_mid_temt", 32'(mid_temt), 32'd0);
    chk("f3_temt", 32'(temt), 32'd1);
    chk("f_loads", 32'(n_loads - l0), 32'd3);
    fifoen = 1'b0;
    refresh();

    // Host write coinciding with the load
    l0 = n_loads;
    thr_write(8'h96);
    @(negedge pclk);
    chk("s_load", 32'(tsr_load), 32'd1);
    wdat = 8'h69; thr_wr_en = 1'b1;
    @(negedge pclk);
    thr_wr_en = 1'b0;
    chk("s_thre", 32'(thre), 32'd0);
    check_frame("s1", {2'b00, 1'b1, 8'h96, 1'b0}, 10, 160, 1'b1);
    chk("s1_mid_thre", 32'(mid_thre), 32'd0);
    chk("s1_next_load", 32'(tsr_load), 32'd1);
    check_frame("s2", {2'b00, 1'b1, 8'h69, 1'b0}, 10, 160, 1'b0);
    chk("s_temt", 32'(temt), 32'd1);
    chk("s_loads", 32'(n_loads - l0), 32'd2);

    // Break mid-frame
    l0 = n_loads;
    thr_write(8'hFF);
    wait_load("brk");
    repeat (60) @(negedge pclk);
    chk("brk_pre", 32'(txd), 32'd1);
    bc = 1'b1;
    @(negedge pclk);
    seen_high = 1'b0; w = 0;
    while (tx_busy && w < 1000) begin
      if (txd) seen_high = 1'b1;
      @(negedge pclk); w++;
    end
    chk("brk_low", 32'(seen_high), 32'd0);
    chk("brk_done", 32'(tx_busy), 32'd0);
    bc = 1'b0;
    repeat (2) @(negedge pclk);
    chk("brk_release", 32'(txd), 32'd1);
    chk("brk_loads", 32'(n_loads - l0), 32'd1);

    // Reset in the middle of the data bits
    l0 = n_loads;
    thr_write(8'h00);
    wait_load("rst");
    repeat (80) @(negedge pclk);
    chk("rst_pre", 32'(txd), 32'd0);
    preset = 1'b1;
    #1;
    chk("rst_mid_txd", 32'(txd), 32'd1);
    chk("rst_mid_busy", 32'(tx_busy), 32'd0);
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    repeat (200) @(negedge pclk);
    chk("rst_loads", 32'(n_loads - l0), 32'd1);
    chk("rst_post_txd", 32'(txd), 32'd1);
    chk("rst_post_temt", 32'(temt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit sequencer for the UART. It sits between the TX buffering (the THR holding register or the 16-deep TX FIFO) and the serial line. It decides when to pull the next character with `tsr_load`, serialises it as start, data, optional parity and stop bits at 16 baud ticks per bit, and reports the THRE/TEMT status to the register block. It also owns the non-FIFO THR-empty flag and applies break control on `txd`.

## Interface
- No parameters. Oversampling is fixed at 16 baud ticks per bit, and the maximum character width is 8 bits.
- `pclk` in 1: the single clock; all logic is rising-edge.
- `preset` in 1: asynchronous, active-high reset.
- `baud_tick` in 1: one-`pclk` pulse at 16× the baud rate, from the baud generator.
- `tx_data` in 8: next character from the TX buffer. It is valid while `tsr_load`=1.
- `fifoen` in 1: 1 means the source is the TX FIFO; 0 means the source is the THR.
- `tx_fifo_empty` in 1: TX FIFO empty flag.
- `thr_wr_en` in 1: host write to THR; one-cycle pulse.
- `wls` in 2: word length. 00=5, 01=6, 10=7, 11=8 bits.
- `stb` in 1: stop-bit select. 0 gives 1 stop bit; 1 gives 2 stop bits, or 1.5 when `wls`=00.
- `pen` in 1: parity enable.
- `eps` in 1: even parity select.
- `sp` in 1: stick parity.
- `bc` in 1: break control.
- `tsr_load` out 1: one-cycle pulse that pops the FIFO or empties the THR.
- `txd` out 1: serial output; idles at 1.
- `thre` out 1: transmit holding register empty.
- `temt` out 1: transmitter empty.
- `tx_busy` out 1: a frame is in progress (state is not IDLE).

## Operation
- **States:** IDLE, LOAD, START, DATA, PARITY, STOP.
- **Data available:** `avail` = `fifoen` ? ~`tx_fifo_empty` : ~`thr_empty`.
- **IDLE:** `txd`=1. If `avail`, go to LOAD.
- **LOAD (one cycle):**
  - `tsr_load`=1.
  - `tsr` <= `tx_data`.
  - `tick_cnt` <= 0, `bit_cnt` <= 0.
  - Go to START.
- **Bit timing:**
  - `tick_cnt` (4 bits) increments on each `baud_tick`.
  - A bit ends on the `baud_tick` where `tick_cnt`=15; the counter wraps to 0.
  - Each bit therefore lasts exactly 16 ticks.
- **START:** `txd`=0 for 1 bit, then DATA.
- **DATA:**
  - `txd`=`tsr[0]`, sending LSB first.
  - `tsr` shifts right at each bit end and `bit_cnt` increments.
  - After N bits (N = 5 + `wls`), go to PARITY if `pen`, else STOP.
- **PARITY:**
  - Bit value = `sp` ? ~`eps` : (`eps` ? XOR of data bits : XNOR of data bits).
  - Only the low N bits count toward parity.
  - Parity is computed from the loaded character, not the shifted register.
- **STOP:**
  - `txd`=1.
  - Duration is 16 ticks, or 24 ticks when `stb`=1 and `wls`=00, or 32 ticks when `stb`=1 otherwise.
  - A 6-bit stop counter is used.
  - At the end: if `avail`, go directly to LOAD (back-to-back frames, no idle gap); else go to IDLE.
- **Sampling of line controls:** `wls`/`stb`/`pen`/`eps`/`sp` are sampled at LOAD and held for the frame. Mid-frame changes affect only the next frame.
- **Break:** while `bc`=1, `txd`=0 regardless of state. The FSM keeps running, so characters are consumed normally.
- **`thr_empty` flag (internal, reset 1):**
  - Cleared by `thr_wr_en` & ~`fifoen`.
  - Set by `tsr_load` & ~`fifoen`.
  - If a write and a load occur in the same cycle, the write wins and `thr_empty` stays 0. The TSR takes the old character; the THR holds the new one.
- **Status outputs:**
  - `thre` = `fifoen` ? `tx_fifo_empty` : `thr_empty`.
  - `temt` = `thre` & (state==IDLE).
- **Changing `fifoen` mid-frame:** the current frame completes; the next `avail` evaluation uses the new mode.

## Timing
- **Reset values:** state=IDLE, `txd`=1, `tsr_load`=0, `thr_empty`=1, `thre`=1 (in THR mode), `temt`=1, `tx_busy`=0, all counters 0.
- **Reset mid-frame:** `txd` returns to 1 asynchronously and the frame is aborted with no further `tsr_load`.
- **Start of transmission:**
  - `avail` rising in IDLE leads to `tsr_load` on the next cycle.
  - `txd` falls the cycle after `tsr_load`.
- **Frame length** for an 8N1 frame: 160 ticks from the start edge to the end of stop.
- **Back-to-back frames:** `tsr_load` occurs one cycle after the final stop-bit tick, and the next start bit follows one cycle later.
- **Outputs:** `txd` is registered; `tsr_load` is a registered state decode, glitch-free.
- **Load frequency:** at most one `tsr_load` per frame. `tsr_load` is never asserted while `avail`=0, so there is no underflow pop.

## Test plan
- **THR 8N1:** `fifoen`=0, write 0xA5.
  - `tsr_load` fires once and `thre` rises.
  - `txd` = 0, then 1,0,1,0,0,1,0,1, then 1; 16 ticks per bit.
  - `temt`=1 after the stop bit.
- **7E1 and stick parity:**
  - `wls`=10, `pen`=`eps`=1, data 0x55 (four ones) → parity bit 0.
  - `sp`=1, `eps`=0 → parity bit 1.
- **5-bit 1.5 stop:** `wls`=00, `stb`=1, data 0x1F → 5 data bits of 1, stop high for 24 ticks, then IDLE.
- **FIFO back-to-back:** `fifoen`=1, FIFO holds 0x11, 0x22, 0x33.
  - 3 `tsr_load` pulses occur, with no idle gap between frames.
  - `thre` follows `tx_fifo_empty`; `temt` rises only after the third stop bit.
- **Simultaneous write and load:** THR mode, `thr_wr_en` coincides with `tsr_load`.
  - `thr_empty` stays 0.
  - The second character is sent immediately after the first.
- **Break and reset:**
  - `bc`=1 mid-frame → `txd`=0 throughout the frame.
  - `preset` asserted mid-DATA → `txd`=1 and `tx_busy`=0 immediately, with no further `tsr_load`.
